// File: rtl/mano_io_terminal_pkg.sv
// rtl/mano_io_terminal_pkg.sv - shared widths, I/O opcodes and TX state encodings
package mano_io_terminal_pkg;

  localparam int CHAR_W = 8;
  localparam int WORD_W = 16;

  // Core I/O instruction encodings, kept here so core and terminal agree
  localparam logic [WORD_W-1:0] OP_INP = 16'hF800;
  localparam logic [WORD_W-1:0] OP_OUT = 16'hF400;
  localparam logic [WORD_W-1:0] OP_SKI = 16'hF200;
  localparam logic [WORD_W-1:0] OP_SKO = 16'hF100;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/mano_uart_tx.sv
// rtl/mano_uart_tx.sv - 8N1 serialiser with baud counter, bit counter and shift register
module mano_uart_tx
  import mano_io_terminal_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CHAR_W-1:0] data,
  output logic              busy,
  output logic              tx
);

  localparam int CNT_W = 12;

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [CHAR_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              baud_end;

  assign baud_end = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
  assign busy     = (state_q != TX_IDLE);
  assign tx       = tx_q;

  // Next-state logic: each non-idle state lasts one full bit period
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      TX_IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (start) begin
          shift_d = data;
          state_d = TX_START;
          tx_d    = 1'b0;
        end
      end
      TX_START: begin
        baud_d = baud_q + CNT_W'(1);
        if (baud_end) begin
          baud_d  = '0;
          state_d = TX_DATA;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[CHAR_W-1:1]};
        end
      end
      TX_DATA: begin
        baud_d = baud_q + CNT_W'(1);
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[CHAR_W-1:1]};
          end
        end
      end
      TX_STOP: begin
        baud_d = baud_q + CNT_W'(1);
        tx_d   = 1'b1;
        if (baud_end) begin
          baud_d  = '0;
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // State register; reset aborts any frame and forces the line idle-high
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/mano_io_terminal.sv
// rtl/mano_io_terminal.sv - Mano core I/O terminal: keyboard into INPR/FGI, OUTR/FGO onto a UART line
module mano_io_terminal
  import mano_io_terminal_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [CHAR_W-1:0] inpr,
  output logic              fgi,
  input  logic              inp_ack,
  input  logic [CHAR_W-1:0] outr,
  input  logic              out_wr,
  output logic              fgo,
  output logic              out_overrun,
  input  logic [CHAR_W-1:0] kbd_data,
  input  logic              kbd_valid,
  output logic              kbd_ready,
  output logic              tx
);

  logic [CHAR_W-1:0] inpr_q, inpr_d;
  logic              fgi_q, fgi_d;
  logic              ovr_q, ovr_d;
  logic              busy;
  logic              tx_start;

  assign kbd_ready   = ~fgi_q;
  assign inpr        = inpr_q;
  assign fgi         = fgi_q;
  assign fgo         = ~busy;
  assign out_overrun = ovr_q;
  assign tx_start    = out_wr & ~busy;

  // Input flag handshake: a held character waits until the core has read the previous one
  always_comb begin
    inpr_d = inpr_q;
    fgi_d  = fgi_q;
    ovr_d  = ovr_q | (out_wr & busy);
    if (kbd_valid && !fgi_q) begin
      inpr_d = kbd_data;
      fgi_d  = 1'b1;
    end else if (inp_ack && fgi_q) begin
      fgi_d  = 1'b0;
    end
  end

  // Input register, input flag and sticky overrun
  always_ff @(posedge clk) begin
    if (!rst) begin
      inpr_q <= '0;
      fgi_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      inpr_q <= inpr_d;
      fgi_q  <= fgi_d;
      ovr_q  <= ovr_d;
    end
  end

  mano_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .start(tx_start),
    .data (outr),
    .busy (busy),
    .tx   (tx)
  );

endmodule

// File: tb/tb_mano_io_terminal.sv
// tb/tb_mano_io_terminal.sv - directed bench for mano_io_terminal at 4 clocks per bit
module tb_mano_io_terminal;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] inpr;
  logic       fgi;
  logic       inp_ack;
  logic [7:0] outr;
  logic       out_wr;
  logic       fgo;
  logic       out_overrun;
  logic [7:0] kbd_data;
  logic       kbd_valid;
  logic       kbd_ready;
  logic       tx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mano_io_terminal #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .inpr       (inpr),
    .fgi        (fgi),
    .inp_ack    (inp_ack),
    .outr       (outr),
    .out_wr     (out_wr),
    .fgo        (fgo),
    .out_overrun(out_overrun),
    .kbd_data   (kbd_data),
    .kbd_valid  (kbd_valid),
    .kbd_ready  (kbd_ready),
    .tx         (tx)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Expected line level for cycle k (0..10*CPB-1) after the out_wr edge
  function automatic logic frame_bit(input logic [7:0] ch, input int k);
    int slot;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return ch[slot-1];
  endfunction

  // Launch a frame and check all 10*CPB line cycles; optionally inject an extra out_wr
  task automatic check_frame(input logic [7:0] ch, input int ovr_at, input logic [7:0] ovr_ch,
                             input logic exp_ovr_end);
    outr   = ch;
    out_wr = 1'b1;
    tick();
    out_wr = 1'b0;
    for (int k = 0; k < 10*CPB; k++) begin
      total++;
      if (tx !== frame_bit(ch, k) || fgo !== 1'b0) begin
        bad++;
        $display("FAIL frame_%h cyc=%0d tx=%b fgo=%b want tx=%b fgo=0", ch, k, tx, fgo, frame_bit(ch, k));
      end
      if (k == ovr_at) begin
        outr   = ovr_ch;
        out_wr = 1'b1;
      end
      tick();
      out_wr = 1'b0;
      outr   = ch;
    end
    total++;
    if (fgo !== 1'b1 || tx !== 1'b1 || out_overrun !== exp_ovr_end) begin
      bad++;
      $display("FAIL frame_end_%h fgo=%b tx=%b ovr=%b want fgo=1 tx=1 ovr=%b", ch, fgo, tx, out_overrun, exp_ovr_end);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (tx !== 1'b1 || fgo !== 1'b1 || fgi !== 1'b0 || inpr !== 8'h00 || kbd_ready !== 1'b1 || out_overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset tx=%b fgo=%b fgi=%b inpr=%h rdy=%b ovr=%b want 1 1 0 00 1 0", tx, fgo, fgi, inpr, kbd_ready, out_overrun);
    end
  endtask

  task automatic test_input();
    kbd_valid = 1'b1;
    kbd_data  = 8'h41;
    tick();
    total++;
    if (inpr !== 8'h41 || fgi !== 1'b1 || kbd_ready !== 1'b0) begin
      bad++;
      $display("FAIL kbd_accept inpr=%h fgi=%b rdy=%b want 41 1 0", inpr, fgi, kbd_ready);
    end
    kbd_data = 8'h42;
    tick(); tick(); tick();
    total++;
    if (inpr !== 8'h41 || fgi !== 1'b1) begin
      bad++;
      $display("FAIL kbd_stall inpr=%h fgi=%b want 41 1", inpr, fgi);
    end
    inp_ack = 1'b1;
    tick();
    inp_ack = 1'b0;
    total++;
    if (inpr !== 8'h41 || fgi !== 1'b0 || kbd_ready !== 1'b1) begin
      bad++;
      $display("FAIL ack_clear inpr=%h fgi=%b rdy=%b want 41 0 1", inpr, fgi, kbd_ready);
    end
    tick();
    total++;
    if (inpr !== 8'h42 || fgi !== 1'b1) begin
      bad++;
      $display("FAIL kbd_second inpr=%h fgi=%b want 42 1", inpr, fgi);
    end
    kbd_valid = 1'b0;
    inp_ack   = 1'b1;
    tick();
    inp_ack = 1'b0;
    total++;
    if (fgi !== 1'b0 || inpr !== 8'h42) begin
      bad++;
      $display("FAIL ack_second fgi=%b inpr=%h want 0 42", fgi, inpr);
    end
    inp_ack = 1'b1;
    tick();
    inp_ack = 1'b0;
    total++;
    if (fgi !== 1'b0 || inpr !== 8'h42) begin
      bad++;
      $display("FAIL ack_idle fgi=%b inpr=%h want 0 42", fgi, inpr);
    end
  endtask

  task automatic test_frame();
    check_frame(8'hA5, -1, 8'h00, 1'b0);
  endtask

  task automatic test_overrun();
    check_frame(8'hA5, 9, 8'h3C, 1'b1);
    for (int k = 0; k < 12; k++) tick();
    total++;
    if (tx !== 1'b1 || fgo !== 1'b1 || out_overrun !== 1'b1) begin
      bad++;
      $display("FAIL no_second_frame tx=%b fgo=%b ovr=%b want 1 1 1", tx, fgo, out_overrun);
    end
  endtask

  task automatic test_coincident();
    do_reset();
    check_frame(8'h5A, 10*CPB-1, 8'h77, 1'b1);
    tick(); tick();
    total++;
    if (fgo !== 1'b1 || tx !== 1'b1) begin
      bad++;
      $display("FAIL coincident_ignored fgo=%b tx=%b want 1 1", fgo, tx);
    end
  endtask

  task automatic test_mid_reset();
    outr   = 8'h00;
    out_wr = 1'b1;
    tick();
    out_wr = 1'b0;
    for (int k = 0; k < 13; k++) tick();
    rst = 1'b0;
    tick();
    total++;
    if (tx !== 1'b1 || fgo !== 1'b1 || out_overrun !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset tx=%b fgo=%b ovr=%b want 1 1 0", tx, fgo, out_overrun);
    end
    rst = 1'b1;
    tick();
    check_frame(8'hC3, -1, 8'h00, 1'b0);
  endtask

  task automatic test_concurrent();
    outr   = 8'hFF;
    out_wr = 1'b1;
    tick();
    out_wr = 1'b0;
    for (int k = 0; k < 10*CPB; k++) begin
      total++;
      if (tx !== (k >= CPB) || fgo !== 1'b0) begin
        bad++;
        $display("FAIL conc_frame cyc=%0d tx=%b fgo=%b want tx=%b fgo=0", k, tx, fgo, (k >= CPB));
      end
      if (k == 6) begin
        total++;
        if (inpr !== 8'h0D || fgi !== 1'b1) begin
          bad++;
          $display("FAIL conc_kbd inpr=%h fgi=%b want 0d 1", inpr, fgi);
        end
      end
      if (k == 11) begin
        total++;
        if (inpr !== 8'h0D || fgi !== 1'b0) begin
          bad++;
          $display("FAIL conc_ack inpr=%h fgi=%b want 0d 0", inpr, fgi);
        end
      end
      kbd_valid = (k == 5);
      kbd_data  = 8'h0D;
      inp_ack   = (k == 10);
      tick();
    end
    kbd_valid = 1'b0;
    inp_ack   = 1'b0;
    total++;
    if (fgo !== 1'b1 || tx !== 1'b1 || fgi !== 1'b0) begin
      bad++;
      $display("FAIL conc_end fgo=%b tx=%b fgi=%b want 1 1 0", fgo, tx, fgi);
    end
  endtask

  initial begin
    rst       = 1'b0;
    inp_ack   = 1'b0;
    outr      = 8'h00;
    out_wr    = 1'b0;
    kbd_data  = 8'h00;
    kbd_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_input();
    test_frame();
    test_overrun();
    test_coincident();
    test_mid_reset();
    test_concurrent();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
